m_mem_master: RTL

Initiator-side load/store controller for the MEM stage of the 5-stage pipeline, driving the word-addressed synchronous data memory (combinational read, write committed on the falling clock edge). Accepts byte/halfword/word loads and stores on byte addresses, converts them to word accesses, and performs read-modify-write for sub-word stores. Stalls the pipeline through a ready handshake and returns sign- or zero-extended load data.

---
 rtl/m_mem_pkg.sv | 40 ++++
 rtl/m_mem_lane.sv | 49 ++++
 rtl/m_mem_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/m_mem_pkg.sv
// rtl/m_mem_pkg.sv - shared size encodings, FSM states and lane helpers for m_mem_master
package m_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Encoding 11 behaves as a word access everywhere downstream.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    // Byte offset of the addressed lane after aligning the address down.
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return a;
            SZ_HALF: return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return |a;
        endcase
    endfunction

endpackage

// File: rtl/m_mem_lane.sv
// rtl/m_mem_lane.sv - combinational lane extract/extend for loads and lane merge for sub-word stores
//   load_word   : word read from memory; load_data is the addressed lane, extended
//   merge_word  : word captured for read-modify-write; merge_data has the lane replaced by wdata
//   size/offset : normalised access size and aligned byte offset within the word
//   is_unsigned : zero-extend loads when set, sign-extend otherwise
module m_mem_lane
    import m_mem_pkg::*;
#(
    parameter int REG_SIZE = 32
) (
    input  logic [REG_SIZE-1:0] load_word,
    input  logic [REG_SIZE-1:0] merge_word,
    input  logic [REG_SIZE-1:0] wdata,
    input  logic [1:0]          size,
    input  logic [1:0]          offset,
    input  logic                is_unsigned,
    output logic [REG_SIZE-1:0] load_data,
    output logic [REG_SIZE-1:0] merge_data
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;
    logic              sign_bit;

    always_comb begin
        byte_lane  = load_word[{offset, 3'b000} +: BYTE_W];
        half_lane  = load_word[{offset[1], 4'b0000} +: HALF_W];
        sign_bit   = 1'b0;
        load_data  = load_word;
        merge_data = merge_word;
        case (size)
            SZ_BYTE: begin
                sign_bit  = ~is_unsigned & byte_lane[BYTE_W-1];
                load_data = {{(REG_SIZE-BYTE_W){sign_bit}}, byte_lane};
                merge_data[{offset, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                sign_bit  = ~is_unsigned & half_lane[HALF_W-1];
                load_data = {{(REG_SIZE-HALF_W){sign_bit}}, half_lane};
                merge_data[{offset[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            end
            default: begin
                load_data  = load_word;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/m_mem_master.sv
// rtl/m_mem_master.sv - MEM-stage load/store controller for a word-addressed synchronous memory
//   Optional feature macro: M_MEM_MASTER_ALIGN_TRAP_EN (misaligned half/word requests trap instead
//   of being aligned down).
//   req_*        : load/store request with valid/ready handshake (byte address, right-justified data)
//   rsp_valid    : one-cycle pulse; rsp_rdata carries extended load data (0 for stores/traps)
//   addr_err     : misaligned-request flag, valid with rsp_valid
//   mem_*        : word-indexed memory port; write commits on the falling clock edge
module m_mem_master
    import m_mem_pkg::*;
#(
    parameter  int REG_SIZE = 32,
    parameter  int N_REG    = 256,
    localparam int AW       = $clog2(N_REG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [31:0]         req_addr,
    input  logic [REG_SIZE-1:0] req_wdata,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [REG_SIZE-1:0] rsp_rdata,
    output logic                addr_err,
    output logic                mem_read,
    output logic                mem_write,
    output logic [AW-1:0]       mem_address,
    output logic [REG_SIZE-1:0] mem_write_data,
    input  logic [REG_SIZE-1:0] mem_read_data
);

    state_t              state_q, state_d;
    logic                we_q, uns_q;
    logic [1:0]          size_q;
    logic [AW+1:0]       addr_q;
    logic [REG_SIZE-1:0] wdata_q, merge_q, rsp_q;
    logic [REG_SIZE-1:0] load_data, merge_data;
    logic [1:0]          size_in;
    logic                trap;

    assign size_in = norm_size(req_size);

`ifdef M_MEM_MASTER_ALIGN_TRAP_EN
    logic err_q;
    assign trap     = misaligned(size_in, req_addr[1:0]);
    assign addr_err = rsp_valid & err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state_q == IDLE && req_valid)
            err_q <= trap;
    end
`else
    assign trap     = 1'b0;
    assign addr_err = 1'b0;
`endif

    m_mem_lane #(.REG_SIZE(REG_SIZE)) u_lane (
        .load_word   (mem_read_data),
        .merge_word  (merge_q),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (lane_offset(size_q, addr_q[1:0])),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Low address bits select the lane; the word index drops them, which also
    // aligns misaligned requests down when trapping is not built in.
    assign mem_address = addr_q[AW+1:2];
    assign rsp_rdata   = rsp_valid ? rsp_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Memory strobes depend only on state and latched request so they stay
    // stable through the falling edge where the memory commits.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = trap ? RESP : ACCESS;
            end
            ACCESS: begin
                if (we_q && size_q == SZ_WORD) begin
                    mem_write      = 1'b1;
                    mem_write_data = wdata_q;
                    state_d        = RESP;
                end else begin
                    mem_read = 1'b1;
                    state_d  = we_q ? MERGE_WR : RESP;
                end
            end
            MERGE_WR: begin
                mem_write      = 1'b1;
                mem_write_data = merge_data;
                state_d        = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rsp_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= size_in;
                        addr_q  <= req_addr[AW+1:0];
                        wdata_q <= req_wdata;
                        rsp_q   <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q)
                        rsp_q <= load_data;
                    else
                        merge_q <= mem_read_data;
                end
                default: ;
            endcase
        end
    end

endmodule
